// File: rtl/spi_eeprom_responder_if.sv
// rtl/spi_eeprom_responder_if.sv - SPI bus and status signals between host and EEPROM responder
interface spi_eeprom_responder_if;
    logic spi_clk;
    logic ss;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic wel;
    logic busy;

    modport master (
        output spi_clk, ss, mosi,
        input  miso, miso_oe, wel, busy
    );

    modport slave (
        input  spi_clk, ss, mosi,
        output miso, miso_oe, wel, busy
    );
endinterface

// File: rtl/spi_eeprom_responder.sv
// rtl/spi_eeprom_responder.sv - SPI mode-0 EEPROM responder (READ/WRITE/WREN/WRDI/RDSR)
module spi_eeprom_responder #(
    parameter int DEPTH = 256,
    parameter int PAGE  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_eeprom_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PMASK = AW'(PAGE - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, RDSR, IGNORE} state_t;

    state_t        state, state_next;
    logic [1:0]    sclk_sync, ss_sync, mosi_sync;
    logic          sclk_prev, ss_prev;
    logic          sclk_r, ss_r, mosi_r;
    logic          sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [14:0]   shift, shift_next;
    logic [AW-1:0] addr, addr_next, addr_page_inc;
    logic [7:0]    out_sr, out_next, wr_data, status;
    logic          miso_q, miso_next, oe_q, oe_next;
    logic          wel_q, wel_next, is_read, is_read_next;
    logic          mem_we;
    logic [7:0]    mem [DEPTH];

    assign sclk_r    = sclk_sync[1];
    assign ss_r      = ss_sync[1];
    assign mosi_r    = mosi_sync[1];
    assign sclk_rise = sclk_r & ~sclk_prev;
    assign sclk_fall = ~sclk_r & sclk_prev;
    assign ss_rise   = ss_r & ~ss_prev;
    assign ss_fall   = ~ss_r & ss_prev;

    assign wr_data       = {shift[6:0], mosi_r};
    assign status        = {6'b0, wel_q, 1'b0};
    // Page-mode increment: low page bits wrap, upper bits hold
    assign addr_page_inc = (addr & ~PMASK) | ((addr + AW'(1)) & PMASK);

    assign bus.miso    = miso_q;
    assign bus.miso_oe = oe_q;
    assign bus.wel     = wel_q;
    assign bus.busy    = ~ss_r;

    // Two-flop synchronisers plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.spi_clk};
            ss_sync   <= {ss_sync[0], bus.ss};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sclk_prev <= sclk_r;
            ss_prev   <= ss_r;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            addr    <= '0;
            out_sr  <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            wel_q   <= 1'b0;
            is_read <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            addr    <= addr_next;
            out_sr  <= out_next;
            miso_q  <= miso_next;
            oe_q    <= oe_next;
            wel_q   <= wel_next;
            is_read <= is_read_next;
        end
    end

    // Memory array has no reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= wr_data;
    end

    // Next-state and datapath decode; ss rise outranks any spi_clk edge
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        addr_next    = addr;
        out_next     = out_sr;
        miso_next    = miso_q;
        oe_next      = oe_q;
        wel_next     = wel_q;
        is_read_next = is_read;
        mem_we       = 1'b0;
        if (ss_rise) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            oe_next      = 1'b0;
            miso_next    = 1'b0;
            if (state == WRITE) wel_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state_next   = CMD;
                        bit_cnt_next = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_next   = {shift[13:0], mosi_r};
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next = '0;
                            case (wr_data)
                                8'h06: begin wel_next = 1'b1; state_next = IGNORE; end
                                8'h04: begin wel_next = 1'b0; state_next = IGNORE; end
                                8'h05: begin state_next = RDSR; oe_next = 1'b1; end
                                8'h03: begin state_next = ADDR; is_read_next = 1'b1; end
                                8'h02: begin state_next = ADDR; is_read_next = 1'b0; end
                                default: state_next = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        shift_next   = {shift[13:0], mosi_r};
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            bit_cnt_next = '0;
                            addr_next    = AW'({shift, mosi_r});
                            state_next   = is_read ? READ : WRITE;
                            oe_next      = is_read;
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        bit_cnt_next = {1'b0, bit_cnt[2:0] + 3'd1};
                        if (bit_cnt[2:0] == 3'd0) begin
                            miso_next = mem[addr][7];
                            out_next  = {mem[addr][6:0], 1'b0};
                            addr_next = addr + AW'(1);
                        end else begin
                            miso_next = out_sr[7];
                            out_next  = {out_sr[6:0], 1'b0};
                        end
                    end
                end
                RDSR: begin
                    if (sclk_fall) begin
                        bit_cnt_next = {1'b0, bit_cnt[2:0] + 3'd1};
                        if (bit_cnt[2:0] == 3'd0) begin
                            miso_next = status[7];
                            out_next  = {status[6:0], 1'b0};
                        end else begin
                            miso_next = out_sr[7];
                            out_next  = {out_sr[6:0], 1'b0};
                        end
                    end
                end
                WRITE: begin
                    if (sclk_rise) begin
                        shift_next   = {shift[13:0], mosi_r};
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next = '0;
                            mem_we       = wel_q;
                            addr_next    = addr_page_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// tb/tb_spi_eeprom_responder.sv - directed self-checking bench for spi_eeprom_responder
module tb_spi_eeprom_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   fails = 0;
    logic oe_any;
    logic [7:0]  rx;
    logic [31:0] rd;

    spi_eeprom_responder_if bus();

    spi_eeprom_responder #(.DEPTH(256), .PAGE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.mosi = tx[i];
            #60;
            rxb[i] = bus.miso;
            oe_any = oe_any | bus.miso_oe;
            bus.spi_clk = 1'b1;
            #60;
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic sel;
        bus.ss = 1'b0;
        #60;
    endtask

    task automatic desel;
        #60;
        bus.ss = 1'b1;
        #100;
    endtask

    task automatic single(input logic [7:0] op);
        logic [7:0] d;
        sel();
        xfer(op, 8, d);
        desel();
    endtask

    task automatic rdsr(output logic [7:0] st);
        sel();
        xfer(8'h05, 8, st);
        xfer(8'h00, 8, st);
        desel();
    endtask

    task automatic do_read(input logic [15:0] a, input int n, output logic [31:0] data);
        logic [7:0] d;
        data = '0;
        sel();
        xfer(8'h03, 8, d);
        xfer(a[15:8], 8, d);
        xfer(a[7:0], 8, d);
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, 8, d);
            data = {data[23:0], d};
        end
        desel();
    endtask

    task automatic do_write(input logic [15:0] a, input int n, input logic [31:0] data);
        logic [7:0] d;
        sel();
        xfer(8'h02, 8, d);
        xfer(a[15:8], 8, d);
        xfer(a[7:0], 8, d);
        for (int k = n - 1; k >= 0; k--) xfer(data[8*k +: 8], 8, d);
        desel();
    endtask

    initial begin
        bus.spi_clk = 1'b0;
        bus.ss      = 1'b1;
        bus.mosi    = 1'b0;
        oe_any      = 1'b0;
        #25;
        check("reset_miso", {31'b0, bus.miso}, 32'h0);
        check("reset_oe",   {31'b0, bus.miso_oe}, 32'h0);
        check("reset_wel",  {31'b0, bus.wel}, 32'h0);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        #20;
        reset = 1'b0;
        #50;

        single(8'h06); do_write(16'h0010, 4, 32'hA55AC33C);
        check("wel_after_write", {31'b0, bus.wel}, 32'h0);
        single(8'h06); do_write(16'h00FF, 1, 32'h77);
        single(8'h06); do_write(16'h0000, 1, 32'h88);
        single(8'h06); do_write(16'h0005, 1, 32'h4E);

        oe_any = 1'b0;
        do_read(16'h0010, 4, rd);
        check("read_10_32bit", rd, 32'hA55AC33C);
        check("read_oe_seen", {31'b0, oe_any}, 32'h1);
        check("oe_after_ss", {31'b0, bus.miso_oe}, 32'h0);

        single(8'h06);
        check("wel_after_wren", {31'b0, bus.wel}, 32'h1);
        rdsr(rx);
        check("rdsr_wel1", {24'b0, rx}, 32'h02);
        do_write(16'h001E, 3, 32'h112233);
        check("wel_cleared", {31'b0, bus.wel}, 32'h0);
        rdsr(rx);
        check("rdsr_wel0", {24'b0, rx}, 32'h00);
        do_read(16'h001E, 2, rd);
        check("page_1e_1f", rd, 32'h1122);
        do_read(16'h0010, 1, rd);
        check("page_wrap_10", rd, 32'h33);

        do_write(16'h0005, 1, 32'hFF);
        do_read(16'h0005, 1, rd);
        check("wel0_no_write", rd, 32'h4E);
        check("wel0_stays", {31'b0, bus.wel}, 32'h0);

        do_read(16'h00FF, 2, rd);
        check("read_wrap_ff", rd, 32'h7788);

        single(8'h06);
        sel();
        xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h12, 8, rx);
        xfer(8'h99, 8, rx); xfer(8'hE7, 4, rx);
        desel();
        do_read(16'h0012, 2, rd);
        check("partial_discard", rd, 32'h993C);

        single(8'h06);
        sel();
        xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h11, 8, rx);
        xfer(8'hF0, 4, rx);
        reset = 1'b1;
        #30;
        check("midrst_miso", {31'b0, bus.miso}, 32'h0);
        check("midrst_oe",   {31'b0, bus.miso_oe}, 32'h0);
        check("midrst_wel",  {31'b0, bus.wel}, 32'h0);
        check("midrst_busy", {31'b0, bus.busy}, 32'h0);
        bus.ss = 1'b1;
        #50;
        reset = 1'b0;
        #50;
        do_read(16'h0011, 1, rd);
        check("after_reset_read", rd, 32'h5A);

        single(8'h06);
        oe_any = 1'b0;
        sel();
        xfer(8'hAB, 8, rx);
        xfer(8'h5C, 8, rx);
        check("ignore_miso_0", {24'b0, rx}, 32'h0);
        xfer(8'hFF, 8, rx);
        desel();
        check("ignore_oe_low", {31'b0, oe_any}, 32'h0);
        check("ignore_wel_kept", {31'b0, bus.wel}, 32'h1);
        do_read(16'h0013, 1, rd);
        check("ignore_mem_kept", rd, 32'h3C);
        single(8'h04);
        check("wrdi_clears", {31'b0, bus.wel}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/spi_eeprom_responder.md
SPI_EEPROM_RESPONDER -- requirements
Module: spi_eeprom_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: memory size in bytes, a power of two.
REQ-002 SHALL have parameter PAGE, default 16: write page size in bytes, a power of two, at most DEPTH.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port spi_clk, input, 1: SPI serial clock (mode 0), asynchronous to clk.
REQ-006 SHALL have port ss, input, 1: slave select, active-low.
REQ-007 SHALL have port mosi, input, 1: serial data in, MSB first.
REQ-008 SHALL have port miso, output, 1: serial data out, MSB first.
REQ-009 SHALL have port miso_oe, output, 1: miso drive enable.
REQ-010 SHALL have port wel, output, 1: write-enable latch state.
REQ-011 SHALL have port busy, output, 1: high while ss is low (synchronised).

Function
REQ-012 SHALL pass spi_clk, ss and mosi each through a 2-flop synchroniser into clk; all decoding SHALL use the synchronised signals.
REQ-013 SHALL operate correctly for spi_clk high and low times each of at least 4 clk cycles.
REQ-014 SHALL sample mosi on each synchronised rising spi_clk edge and update miso on each synchronised falling edge.
REQ-015 SHALL use states IDLE, CMD, ADDR, READ, WRITE, RDSR, IGNORE.
REQ-016 SHALL move IDLE->CMD on synchronised ss falling; a synchronised ss rising in any state SHALL return to IDLE, clear the bit counter and drop miso_oe within 1 clk.
REQ-017 SHALL decode the opcode after 8 bits in CMD: 0x06 sets WEL, then IGNORE; 0x04 clears WEL, then IGNORE; 0x05 goes to RDSR; 0x03 and 0x02 go to ADDR; any other opcode goes to IGNORE.
REQ-018 SHALL accept a 16-bit address in ADDR, use only the low log2(DEPTH) bits, then enter READ or WRITE.
REQ-019 READ SHALL place the MSB of mem[addr] on miso at the first falling edge after the last address bit, then stream bytes with the address incrementing and wrapping from DEPTH-1 to 0.
REQ-020 RDSR SHALL repeatedly shift the status byte {6'b0, WEL, 1'b0}; bit 0 (WIP) SHALL always be 0.
REQ-021 WRITE SHALL assemble each 8-bit data byte and store it to mem[addr] only if WEL=1; the address SHALL increment within the page, so the low log2(PAGE) bits wrap and the upper bits are held.
REQ-022 SHALL discard a partial data byte (fewer than 8 bits) at ss rise without writing it.
REQ-023 SHALL clear WEL on ss rise after a WRITE command that completed its address phase, whether or not data bytes followed.
REQ-024 WRITE with WEL=0 SHALL leave memory unchanged and leave WEL at 0.
REQ-025 IGNORE SHALL keep miso_oe low and ignore mosi until ss rises.
REQ-026 miso_oe SHALL be high only in READ and RDSR; miso SHALL be 0 when miso_oe is low.
REQ-027 A rising and falling spi_clk edge SHALL never be processed in the same clk cycle; ss rising SHALL take priority over a coincident spi_clk edge.

Reset
REQ-028 reset SHALL asynchronously force: state IDLE, WEL=0, miso=0, miso_oe=0, busy=0, bit counter=0, address=0, synchronisers to idle values (ss=1, spi_clk=0, mosi=0).
REQ-029 Memory contents SHALL NOT be affected by reset.
REQ-030 reset asserted mid-transaction SHALL abort the transaction with no partial write; after reset release, the responder SHALL wait for a fresh ss falling edge.

Verification
REQ-031 Preload mem[0x10..0x13]=A5,5A,C3,3C; send READ 0x03 addr 0x0010 and clock 32 bits -> miso returns A5 5A C3 3C.
REQ-032 Send WREN; RDSR -> status 0x02; send WRITE addr 0x001E data 11 22 33, then ss high -> mem[1E]=11, mem[1F]=22, mem[10]=33 (page wrap), and RDSR returns 0x00.
REQ-033 With WEL=0, send WRITE addr 0x0005 data FF -> mem[05] is unchanged and WEL stays 0.
REQ-034 READ at addr 0x00FF with DEPTH=256 over 2 bytes -> returns mem[FF] then mem[00].
REQ-035 Assert reset while 4 bits of a WRITE data byte have been received -> no memory change, outputs at reset values, and a subsequent READ works normally.
REQ-036 Send opcode 0xAB followed by 16 clocks -> miso_oe stays 0, memory and WEL are unchanged.
